// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver.
//   - Baud divisors (clock cycles per bit), 12 MHz system clock, same values uart_tx uses.
//   - Receiver FSM state type.
//   - Start-edge helper.
package uart_rx_pkg;

  // Clock cycles per bit at 12 MHz.
  localparam int unsigned B115200 = 104;
  localparam int unsigned B57600  = 208;
  localparam int unsigned B38400  = 313;
  localparam int unsigned B19200  = 625;
  localparam int unsigned B9600   = 1250;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // High-to-low transition of the synchronised line: now low, one cycle ago high.
  function automatic logic fall_edge(input logic rx_now, input logic rx_prev);
    return ~rx_now & rx_prev;
  endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// uart_rx_baud: loadable bit-timing down-counter for the UART receiver.
//   clk         system clock
//   rst         synchronous active-high reset
//   i_load      load a full bit period (BAUD-1)
//   i_load_half load half a bit period (BAUD/2-1), used to reach mid start bit
//   o_tick      high in the cycle the loaded counter reaches zero
// After a tick the counter is idle (unloaded) until loaded again, so a tick
// that is not followed by a load never repeats.
module uart_rx_baud #(
  parameter int unsigned BAUD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_load_half,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(BAUD);
  localparam logic [CW-1:0] FullLoad = CW'(BAUD - 1);
  localparam logic [CW-1:0] HalfLoad = CW'(BAUD / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic          r_loaded;

  assign o_tick = r_loaded && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_loaded <= 1'b0;
    end else if (i_load_half) begin
      r_cnt    <= HalfLoad;
      r_loaded <= 1'b1;
    end else if (i_load) begin
      r_cnt    <= FullLoad;
      r_loaded <= 1'b1;
    end else if (r_loaded) begin
      if (r_cnt == '0) begin
        r_loaded <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
//   clk          system clock
//   rst          synchronous active-high reset
//   i_rx         asynchronous serial line, idle high
//   o_data       last correctly framed byte, held until the next good frame
//   o_valid      one-cycle pulse when o_data is updated
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high whenever a frame is in progress
// The line is synchronised by two flops, a falling edge starts a frame, and
// every bit is sampled at mid-bit using uart_rx_baud.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  // Synchroniser and edge-detect flops reset high so leaving reset is not a fall.
  logic r_sync1;
  logic r_rx_s;
  logic r_rx_d;

  rx_state_e  r_state;
  rx_state_e  w_state_next;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_frame_err;

  logic w_fall;
  logic w_tick;
  logic w_load;
  logic w_load_half;
  logic w_shift_en;
  logic w_clr_idx;
  logic w_good;
  logic w_bad;
  logic w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_fall = fall_edge(r_rx_s, r_rx_d);

  uart_rx_baud #(
    .BAUD (BAUD)
  ) u_baud (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_half (w_load_half),
    .o_tick      (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_fall) w_state_next = StStart;
      end
      StStart: begin
        // A high line at mid start bit was only a glitch.
        if (w_tick) w_state_next = r_rx_s ? StIdle : StData;
      end
      StData: begin
        if (w_tick && (r_idx == 3'd7)) w_state_next = StStop;
      end
      StStop: begin
        if (w_tick) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output / control decode.
  always_comb begin
    w_load      = 1'b0;
    w_load_half = 1'b0;
    w_shift_en  = 1'b0;
    w_clr_idx   = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_busy      = 1'b0;
        w_load_half = w_fall;
      end
      StStart: begin
        if (w_tick && !r_rx_s) begin
          w_load    = 1'b1;
          w_clr_idx = 1'b1;
        end
      end
      StData: begin
        if (w_tick) begin
          w_load     = 1'b1;
          w_shift_en = 1'b1;
        end
      end
      StStop: begin
        if (w_tick) begin
          w_good = r_rx_s;
          w_bad  = ~r_rx_s;
        end
      end
      default: w_busy = 1'b0;
    endcase
  end

  // Datapath: shift register, bit index and registered result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= 8'h00;
      r_idx       <= 3'd0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_good;
      r_frame_err <= w_bad;
      if (w_good) r_data <= r_shift;
      if (w_clr_idx) begin
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + 3'd1;
      end
      // LSB arrives first, so shifting right leaves bit 0 in r_shift[0].
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned BAUD     = 16;
  localparam int          HALF     = BAUD / 2;
  localparam int          STOP_OFF = HALF + 9 * BAUD;
  localparam int          LATENCY  = 3 + HALF + 9 * BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx #(
    .BAUD (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state (frame timed by offsets from the detected fall).
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_d = 1'b1;
  logic       m_rs, m_rd;
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  int         m_off;
  logic [7:0] m_bits = 8'h00;
  bit         model_live = 1'b0;
  logic       e_valid = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [7:0] e_data = 8'h00;

  // Observed-event bookkeeping.
  int         n_valid = 0;
  int         n_err = 0;
  int         last_valid_cyc = -1;
  bit         busy_seen = 1'b0;
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: evaluated on every rising edge from the inputs the DUT sees.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_d = 1'b1;
        m_active = 1'b0;
        e_valid = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_data = 8'h00;
        model_live = 1'b1;
      end else begin
        m_rs = m_s2;
        m_rd = m_d;
        m_d  = m_s2;
        m_s2 = m_s1;
        m_s1 = i_rx;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!m_active) begin
          if (!m_rs && m_rd) begin
            m_active = 1'b1;
            m_t0     = cyc;
          end
        end else begin
          m_off = cyc - m_t0;
          if (m_off == HALF) begin
            if (m_rs) m_active = 1'b0;
          end else if (m_off == STOP_OFF) begin
            if (m_rs) begin
              e_valid = 1'b1;
              e_data  = m_bits;
            end else begin
              e_err = 1'b1;
            end
            m_active = 1'b0;
          end else if (m_off > HALF && ((m_off - HALF) % BAUD) == 0) begin
            m_bits[(m_off - HALF) / BAUD - 1] = m_rs;
          end
        end
        e_busy = m_active;
      end
    end
  end

  // Compare process: every falling edge once the model has seen reset.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("o_valid", 32'(o_valid), 32'(e_valid));
        check("o_frame_err", 32'(o_frame_err), 32'(e_err));
        check("o_busy", 32'(o_busy), 32'(e_busy));
        check("o_data", 32'(o_data), 32'(e_data));
        if (o_valid === 1'b1) begin
          n_valid++;
          last_valid_cyc = cyc;
          got_q.push_back(o_data);
        end
        if (o_frame_err === 1'b1) n_err++;
        if (o_busy === 1'b1) busy_seen = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    i_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      i_rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits(b, 8);
    i_rx = stop;
    repeat (BAUD) @(negedge clk);
  endtask

  int         t_start;
  int         lat;
  int         gap;
  int         kind;
  logic [7:0] rb;

  initial begin
    rst  = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle line after reset.
    idle(100);
    check("idle_valid_count", 32'(n_valid), 32'd0);
    check("idle_err_count", 32'(n_err), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_data", 32'(o_data), 32'h00);

    // Single frame 8'hA5 with latency measurement.
    t_start = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    lat = last_valid_cyc - t_start;
    check("a5_valid_count", 32'(n_valid), 32'd1);
    check("a5_data", 32'(o_data), 32'hA5);
    check("a5_model_data", 32'(e_data), 32'hA5);
    check("a5_err_count", 32'(n_err), 32'd0);
    check("a5_latency_ok", 32'(lat >= LATENCY - 1 && lat <= LATENCY + 1), 32'd1);

    // Back-to-back 8'h00 then 8'hFF.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_valid_count", 32'(n_valid), 32'd3);
    if (got_q.size() >= 3) begin
      check("b2b_first", 32'(got_q[1]), 32'h00);
      check("b2b_second", 32'(got_q[2]), 32'hFF);
    end else begin
      check("b2b_pulses_seen", 32'(got_q.size()), 32'd3);
    end

    // Bad stop bit, then the line held low before returning high.
    send_frame(8'h3C, 1'b0);
    i_rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(200);
    check("ferr_err_count", 32'(n_err), 32'd1);
    check("ferr_valid_count", 32'(n_valid), 32'd3);
    check("ferr_data_held", 32'(o_data), 32'hFF);

    // Short glitch: a false start.
    busy_seen = 1'b0;
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_end", 32'(o_busy), 32'd0);
    check("glitch_valid_count", 32'(n_valid), 32'd3);
    check("glitch_err_count", 32'(n_err), 32'd1);

    // Reset during data bit 4 of 8'h5A, then a clean 8'hC3.
    send_bits(8'h5A, 4);
    i_rx = 8'h5A >> 4 & 8'h01;
    repeat (HALF) @(negedge clk);
    check("rst_mid_busy_before", 32'(o_busy), 32'd1);
    rst  = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_data", 32'(o_data), 32'h00);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_valid_count", 32'(n_valid), 32'd3);
    idle(5);
    send_frame(8'hC3, 1'b1);
    idle(20);
    check("after_rst_data", 32'(o_data), 32'hC3);
    check("after_rst_valid_count", 32'(n_valid), 32'd4);

    // Randomised traffic: good frames, bad stop bits and glitches.
    for (int i = 0; i < 30; i++) begin
      gap  = $urandom_range(0, 24);
      kind = $urandom_range(0, 9);
      rb   = 8'($urandom_range(0, 255));
      idle(gap);
      if (kind < 8) begin
        send_frame(rb, 1'b1);
      end else if (kind == 8) begin
        send_frame(rb, 1'b0);
      end else begin
        i_rx = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        i_rx = 1'b1;
      end
    end
    idle(200);
    check("final_busy", 32'(o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first; the receive-side counterpart of the team's uart_tx, sharing the same baud constants.
- Synchronises the asynchronous serial line and detects the start-bit falling edge.
- Samples each bit at mid-bit and presents the received byte with a one-cycle valid strobe; flags bad stop bits.
- Sits between the board RX pin and the consumer logic (FIFO, command parser, loopback to uart_tx).

Parameters:
- BAUD, default `B115200 (from baudgen.vh): clock cycles per bit; legal range BAUD >= 4.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- i_rx  input  1  asynchronous serial line, idle high
- o_data  output  8  last correctly framed byte; holds until the next good frame
- o_valid  output  1  one-cycle pulse when o_data is updated
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- o_busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset and interface:
  - One clock (clk). Reset rst is synchronous and active-high; all state is cleared on a clk edge while rst=1.
  - Reset values: o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE.
  - Both synchroniser flops and the edge-detect flop reset to 1, so leaving reset never reports a false edge.
- Input path:
  - i_rx passes through a 2-flop synchroniser to give rx_s.
  - A further flop gives rx_d; a fall is detected when rx_s=0 and rx_d=1.
- Baud counter:
  - Down-counter of width $clog2(BAUD).
  - A "tick" is the cycle in which the counter = 0 while loaded.
- States (one-hot or binary, implementer's choice):
  - IDLE: o_busy=0. On fall, load counter with BAUD/2-1 and go to START. Without a fall, stay in IDLE. A line held low never retriggers.
  - START: at tick, sample rx_s.
    - If 1: false start, return to IDLE, no output pulse.
    - If 0: load BAUD-1, clear bit index, go to DATA.
  - DATA: at each tick, shift rx_s into the MSB of an 8-bit shift register (shift right) and increment the 3-bit index; reload BAUD-1. After the tick with index=7, go to STOP.
  - STOP: at tick, sample rx_s.
    - If 1: o_data <= shift register and o_valid=1 for exactly the next cycle.
    - If 0: o_frame_err=1 for one cycle and o_data is unchanged.
    - Either way, go to IDLE.
- Timing:
  - Stop sample occurs BAUD/2 + 9*BAUD cycles after the fall-detect cycle.
  - o_valid and o_frame_err are registered, asserting one cycle after the stop sample.
  - Pin-to-o_valid latency is 3 + BAUD/2 + 9*BAUD cycles; the bench allows ±1.
- Back-to-back frames: a start edge arriving right after a stop bit is caught in IDLE; no dead time beyond the half-bit.
- Reset mid-frame: abandon the frame immediately, no output pulse, and resume edge search after rst deasserts.
- No ready/backpressure: the consumer must accept o_data within one frame time, or it is overwritten.
- o_valid and o_frame_err are never high in the same cycle.

Decomposition:
- The baud constants (`B115200, `B9600, …) stay in the shared header baudgen.vh, used by both uart_tx and uart_rx.
- State encoding localparams are local to the module.
- One sub-module is natural: uart_rx_baud, a loadable down-counter with inputs load and load_half and output tick.
- The synchroniser stays inline.

Test Plan:
- Idle line, rst pulse, then 100 cycles with i_rx=1 -> o_valid and o_frame_err never assert, o_busy=0, o_data=8'h00.
- BAUD=16, send 8'hA5 8N1 -> exactly one o_valid at fall-detect+152+1 (±1), o_data=8'hA5, o_frame_err=0.
- BAUD=16, send 8'h00 then 8'hFF back-to-back with no idle gap -> two o_valid pulses with o_data 8'h00 then 8'hFF.
- BAUD=16, send 8'h3C with a low stop bit -> o_frame_err pulses once, o_valid=0, o_data keeps the previous value; the line is then held low 40 cycles then high -> no new frame is reported until a fresh fall.
- Glitch: i_rx low for 4 cycles (< BAUD/2) -> o_busy rises, then returns to 0 at the START tick; no o_valid, no o_frame_err.
- rst asserted at DATA bit 4 of 8'h5A -> outputs go to their reset values; a following frame 8'hC3 is received correctly.
